// File: rtl/msel_pkg.sv
// ============================================================================
// Module      : msel_pkg
// Description : Shared types and helpers for the matrix scan selector.
//               - msel_state_e       : controller states (IDLE / HOLD / SCAN)
//               - MSEL_DEFAULT_DWELL : default per-cell dwell in scan mode
//               - msel_idx_w()       : index width for N items (minimum 1)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package msel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } msel_state_e;

    localparam int MSEL_DEFAULT_DWELL = 8;

    // Bits needed to index n items; a single item still needs one wire.
    function automatic int msel_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : msel_pkg

`default_nettype wire

// File: rtl/msel_dwell_timer.sv
// ============================================================================
// Module      : msel_dwell_timer
// Description : Down-counter measuring a dwell of DWELL enabled cycles.
//               clr_i reloads the count; tc_o is high on the last enabled
//               cycle of each dwell, and the count reloads behind it.
// Ports       : clk_i  - clock, rising edge
//               rst_ni - synchronous reset, active low (count -> 0)
//               clr_i  - reload count to DWELL-1
//               en_i   - count enable
//               tc_o   - terminal-count pulse
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module msel_dwell_timer
    import msel_pkg::*;
#(
    parameter int DWELL = MSEL_DEFAULT_DWELL
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int              CNT_W = msel_idx_w(DWELL);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = LOAD;
        end else if (en_i) begin
            cnt_d = (cnt_q == '0) ? LOAD : cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && !clr_i && (cnt_q == '0);

endmodule : msel_dwell_timer

`default_nettype wire

// File: rtl/matrix_scan_selector.sv
// ============================================================================
// Module      : matrix_scan_selector
// Description : Registered (column,row) -> linear demux channel selector for
//               a ROWS x COLS matrix, with an automatic scan mode that walks
//               every cell for DWELL cycles each.
// Ports       : clk_i        - clock, rising edge
//               rst_ni       - synchronous reset, active low
//               scan_en_i    - 1 = automatic scan, 0 = manual
//               load_valid_i - manual load strobe (samples mdc_i/mdl_i)
//               mdc_i        - column coordinate
//               mdl_i        - row coordinate
//               dmx_sel_o    - demux channel index
//               sel_valid_o  - dmx_sel_o drives a valid cell
//               load_err_o   - one-cycle pulse on a rejected load
//               frame_done_o - one-cycle pulse when the scan wraps to cell 0
// Options     : MATRIX_SCAN_BLANKING_EN - when defined, sel_valid_o drops for
//               one cycle between scanned cells (cell period DWELL+1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_scan_selector
    import msel_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int CW    = 3,
    parameter int RW    = 3,
    parameter int DWELL = MSEL_DEFAULT_DWELL,
    parameter int SEL_W = msel_idx_w(ROWS * COLS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             scan_en_i,
    input  logic             load_valid_i,
    input  logic [CW-1:0]    mdc_i,
    input  logic [RW-1:0]    mdl_i,
    output logic [SEL_W-1:0] dmx_sel_o,
    output logic             sel_valid_o,
    output logic             load_err_o,
    output logic             frame_done_o
);

    localparam int               CELLS     = ROWS * COLS;
    localparam int               IDX_W     = SEL_W + 1;
    localparam logic [SEL_W-1:0] LAST_CELL = SEL_W'(CELLS - 1);

    msel_state_e      state_q, state_d;
    logic [SEL_W-1:0] dmx_sel_q, dmx_sel_d;
    logic             sel_valid_q, sel_valid_d;
    logic             load_err_q, load_err_d;
    logic             frame_done_q, frame_done_d;

    logic [IDX_W-1:0] load_index;
    logic             load_ok;
    logic             dwell_clr;
    logic             dwell_en;
    logic             dwell_tc;

    // Index is formed one bit wider than the select; the range check works on
    // the raw coordinates, so nothing is truncated before the decision. An
    // in-range coordinate never sets the carry bit; folding it in keeps a
    // wrapped product from ever reaching the demux.
    assign load_index = IDX_W'(mdl_i) * IDX_W'(COLS) + IDX_W'(mdc_i);
    assign load_ok    = (int'(mdc_i) < COLS) && (int'(mdl_i) < ROWS)
                        && !load_index[SEL_W];

    // Timer is held reloaded outside SCAN so every scan entry starts a fresh
    // dwell on cell 0.
    assign dwell_clr = (state_q != SCAN);
`ifdef MATRIX_SCAN_BLANKING_EN
    // The blank cycle is not part of a cell's dwell.
    assign dwell_en  = (state_q == SCAN) && sel_valid_q;
`else
    assign dwell_en  = (state_q == SCAN);
`endif

    msel_dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (dwell_clr),
        .en_i   (dwell_en),
        .tc_o   (dwell_tc)
    );

    // State register (all registered outputs live here as well)
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            dmx_sel_q    <= '0;
            sel_valid_q  <= 1'b0;
            load_err_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dmx_sel_q    <= dmx_sel_d;
            sel_valid_q  <= sel_valid_d;
            load_err_q   <= load_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (scan_en_i) begin
                    state_d = SCAN;
                end else if (load_valid_i && load_ok) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (scan_en_i) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!scan_en_i) begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output next-values
    always_comb begin
        dmx_sel_d    = dmx_sel_q;
        sel_valid_d  = sel_valid_q;
        load_err_d   = 1'b0;
        frame_done_d = 1'b0;
        unique case (state_q)
            IDLE, HOLD: begin
                // scan_en has priority over a simultaneous load
                if (scan_en_i) begin
                    dmx_sel_d   = '0;
                    sel_valid_d = 1'b1;
                end else if (load_valid_i) begin
                    if (load_ok) begin
                        dmx_sel_d   = load_index[SEL_W-1:0];
                        sel_valid_d = 1'b1;
                    end else begin
                        load_err_d  = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (!scan_en_i) begin
                    // Leave scan on the current cell, even from a blank cycle.
                    sel_valid_d = 1'b1;
                end else if (dwell_tc) begin
                    if (dmx_sel_q == LAST_CELL) begin
                        dmx_sel_d    = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        dmx_sel_d    = dmx_sel_q + SEL_W'(1);
                    end
`ifdef MATRIX_SCAN_BLANKING_EN
                    sel_valid_d = 1'b0;
                end else begin
                    sel_valid_d = 1'b1;
`else
                    sel_valid_d = 1'b1;
`endif
                end
            end
            default: begin
                dmx_sel_d   = '0;
                sel_valid_d = 1'b0;
            end
        endcase
    end

    assign dmx_sel_o    = dmx_sel_q;
    assign sel_valid_o  = sel_valid_q;
    assign load_err_o   = load_err_q;
    assign frame_done_o = frame_done_q;

endmodule : matrix_scan_selector

`default_nettype wire

// File: doc/matrix_scan_selector.md
Name: matrix_scan_selector

Overview:
- Registered, parametrised successor to the combinational row/column-to-demux-select decoder.
- Maps a (column, row) coordinate of a ROWS x COLS matrix to a linear demux channel index.
- Adds an automatic scan mode that walks every cell with a programmable dwell time.
- Sits between the coordinate/control logic and the 1-to-N demultiplexer that drives the display matrix.

Parameters:
- ROWS, 4, number of matrix rows (>=1).
- COLS, 4, number of matrix columns (>=1).
- CW, 3, width of the column coordinate input.
- RW, 3, width of the row coordinate input.
- DWELL, 8, clock cycles each cell stays selected in scan mode (>=1).
- SEL_W, $clog2(ROWS*COLS) (minimum 1), width of the select output.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- scan_en  in  1  1 = automatic scan mode, 0 = manual mode.
- load_valid  in  1  manual-mode load strobe; samples mdc/mdl.
- mdc  in  CW  column coordinate.
- mdl  in  RW  row coordinate.
- dmx_sel  out  SEL_W  demux channel index.
- sel_valid  out  1  dmx_sel currently drives a valid cell.
- load_err  out  1  one-cycle pulse: rejected out-of-range load.
- frame_done  out  1  one-cycle pulse when a scan wraps from the last cell to cell 0.

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE, dmx_sel=0, sel_valid=0, load_err=0, frame_done=0, dwell counter=0, scan index=0. Reset takes effect even mid-scan; no partial frame_done is emitted.
- Mapping: index = mdl*COLS + mdc, computed at SEL_W+1 bits; no truncation before the range check.
- Range check: a load is valid only when mdc < COLS and mdl < ROWS.
- States: IDLE, HOLD, SCAN.
- IDLE:
  - load_valid=1 with a valid coordinate -> HOLD. dmx_sel=index and sel_valid=1 on the next cycle (latency 1).
  - load_valid=1 with an invalid coordinate -> stay IDLE; load_err=1 for one cycle.
  - scan_en=1 -> SCAN.
  - If scan_en and load_valid are both 1, scan_en wins and the load is ignored.
- HOLD:
  - A valid load updates dmx_sel after 1 cycle.
  - An invalid load pulses load_err; dmx_sel and sel_valid are unchanged.
  - scan_en=1 -> SCAN.
- SCAN:
  - On entry: scan index=0, dmx_sel=0, sel_valid=1, dwell counter cleared.
  - Each cell is held exactly DWELL cycles, then the index increments.
  - From index ROWS*COLS-1 the index wraps to 0 and frame_done pulses 1 cycle, coincident with dmx_sel=0.
  - load_valid is ignored: no load_err, no change.
  - scan_en=0 -> HOLD next cycle. dmx_sel keeps the last scanned cell and sel_valid stays 1.
- Degenerate ROWS*COLS=1: scan stays at index 0; frame_done pulses every DWELL cycles.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: MATRIX_SCAN_BLANKING_EN.
- Defined: in SCAN, sel_valid drops to 0 for exactly one cycle between consecutive cells, including across the wrap. dmx_sel advances during the blank cycle. Each cell period becomes DWELL+1 cycles. This suppresses ghosting.
- Not defined: sel_valid stays 1 continuously throughout SCAN, and the cell period is DWELL cycles.

Decomposition:
- Shared package msel_pkg:
  - state enum (IDLE, HOLD, SCAN).
  - index-width helper function.
  - constant for the default dwell.
- Sub-module msel_dwell_timer:
  - parametrised down-counter with clear and terminal-count pulse.
  - instantiated once for the scan dwell.

Test Plan:
- Reset then idle: rst_n low 2 cycles -> dmx_sel=0, sel_valid=0, load_err=0, frame_done=0; state IDLE.
- Manual load: load_valid with mdc=2, mdl=3 (defaults) -> dmx_sel=14, sel_valid=1 one cycle later. Then mdc=1, mdl=0 -> dmx_sel=1.
- Out-of-range load: mdc=5, mdl=1 after a prior valid load of 14 -> load_err=1 for exactly one cycle; dmx_sel stays 14.
- Full scan: scan_en=1 with DWELL=8 -> dmx_sel steps 0..15, each held 8 cycles. frame_done pulses once at 128 cycles, coincident with dmx_sel=0. A load_valid during the scan produces no effect.
- Scan exit and reset mid-scan: drop scan_en while dmx_sel=6 -> HOLD with dmx_sel=6, sel_valid=1. Re-enter scan and assert rst_n=0 at index 9 -> all outputs at reset values next cycle.
- MATRIX_SCAN_BLANKING_EN build: DWELL=2 -> sel_valid pattern 1,1,0 repeating; a full frame takes 48 cycles between frame_done pulses.
